// File: rtl/hazard_scoreboard.sv
// Interlock/forwarding scoreboard beside ID: per-register countdowns decide stalls and
// the registered EX operand forwarding selects, including multi-cycle EX operations.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int MAX_LAT  = 4,
  parameter int CW       = $clog2(MAX_LAT + 2)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rs1,
  input  logic                issue_rs1_en,
  input  logic [AW-1:0]       issue_rs2,
  input  logic                issue_rs2_en,
  input  logic [AW-1:0]       issue_rd,
  input  logic                issue_wr,
  input  logic                issue_ld,
  input  logic [CW-1:0]       issue_lat,
  input  logic                flush,
  output logic                stall,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                ex_valid,
  output logic [NUM_REGS-1:0] busy
);

  function automatic logic [CW-1:0] clamp_lat(input logic [CW-1:0] lat);
    if (lat == '0) return CW'(1);
    if (int'(lat) > MAX_LAT) return CW'(MAX_LAT);
    return lat;
  endfunction

  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - CW'(1);
  endfunction

  // Result is {hazard, select}; a load's data is only reachable from MEM/WB.
  function automatic logic [2:0] src_check(input logic en, input logic [CW-1:0] r,
                                           input logic is_ld);
    logic [2:0] res;
    res = 3'b000;
    if (en) begin
      if (int'(r) >= 3)                    res = 3'b100;
      else if (int'(r) == 2)               res = is_ld ? 3'b001 : 3'b010;
      else if (int'(r) == 1 && !is_ld)     res = 3'b001;
    end
    return res;
  endfunction

  logic [CW-1:0]       rem [NUM_REGS];
  logic [NUM_REGS-1:0] ld;

  logic [2:0]    chk_a_p0, chk_b_p0;
  logic [CW-1:0] newrem_p0;
  logic          waw_p0;
  logic          accept_p0;
  logic          wr_en_p0;

  logic [1:0]    fwd_a_p1, fwd_b_p1;
  logic          vld_p1;

  // ID stage: hazard and forwarding decisions against the pre-update table
  always_comb begin
    chk_a_p0  = src_check(issue_rs1_en && (issue_rs1 != '0), rem[issue_rs1], ld[issue_rs1]);
    chk_b_p0  = src_check(issue_rs2_en && (issue_rs2 != '0), rem[issue_rs2], ld[issue_rs2]);
    newrem_p0 = issue_ld ? CW'(3) : clamp_lat(issue_lat) + CW'(1);
    waw_p0    = issue_wr && (issue_rd != '0) && (int'(rem[issue_rd]) > int'(newrem_p0) + 1);
    stall     = issue_valid && !flush && reset && (chk_a_p0[2] || chk_b_p0[2] || waw_p0);
    accept_p0 = issue_valid && !flush && !stall;
    wr_en_p0  = accept_p0 && issue_wr && (issue_rd != '0);
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NUM_REGS; r++) busy[r] = (rem[r] != '0);
  end

  // ID/EX boundary: table update and registered selects
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) rem[r] <= '0;
      ld       <= '0;
      fwd_a_p1 <= 2'b00;
      fwd_b_p1 <= 2'b00;
      vld_p1   <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) rem[r] <= sat_dec(rem[r]);
      if (wr_en_p0) begin
        rem[issue_rd] <= newrem_p0;
        ld[issue_rd]  <= issue_ld;
      end
      fwd_a_p1 <= accept_p0 ? chk_a_p0[1:0] : 2'b00;
      fwd_b_p1 <= accept_p0 ? chk_b_p0[1:0] : 2'b00;
      vld_p1   <= accept_p0;
    end
  end

  assign fwd_a    = fwd_a_p1;
  assign fwd_b    = fwd_b_p1;
  assign ex_valid = vld_p1;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: ALU chain, load-use, multi-cycle, WAW,
// r0/flush, latency clamping and reset, with hand-derived expectations.
module tb_hazard_scoreboard;
  localparam int NUM_REGS = 32;
  localparam int AW = 5;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset;
  logic issue_valid, issue_rs1_en, issue_rs2_en, issue_wr, issue_ld, flush;
  logic [AW-1:0] issue_rs1, issue_rs2, issue_rd;
  logic [CW-1:0] issue_lat;
  logic stall, ex_valid;
  logic [1:0] fwd_a, fwd_b;
  logic [NUM_REGS-1:0] busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NUM_REGS(NUM_REGS), .AW(AW), .MAX_LAT(4), .CW(CW)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs1_en(issue_rs1_en),
    .issue_rs2(issue_rs2), .issue_rs2_en(issue_rs2_en),
    .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_ld(issue_ld),
    .issue_lat(issue_lat), .flush(flush), .stall(stall),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .ex_valid(ex_valid), .busy(busy)
  );

  task automatic drive(input logic v, input logic [AW-1:0] r1, input logic e1,
                       input logic [AW-1:0] r2, input logic e2, input logic [AW-1:0] d,
                       input logic w, input logic l, input logic [CW-1:0] lt, input logic f);
    issue_valid = v; issue_rs1 = r1; issue_rs1_en = e1; issue_rs2 = r2; issue_rs2_en = e2;
    issue_rd = d; issue_wr = w; issue_ld = l; issue_lat = lt; flush = f;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (6) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 3'd4, 1'b0);
    tick();
    vectors++; if (busy !== 32'h20) begin miscompares++; $display("FAIL rst_pre_busy: got %h want 00000020", busy); end
    vectors++; if (ex_valid !== 1'b1) begin miscompares++; $display("FAIL rst_pre_exv: got %b want 1", ex_valid); end
    reset = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd1, 1'b0);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall_forced: got %b want 0", stall); end
    tick();
    tick();
    vectors++; if (busy !== 32'h0) begin miscompares++; $display("FAIL rst_busy: got %h want 0", busy); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %b want 0", stall); end
    vectors++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin miscompares++; $display("FAIL rst_fwd: got %b/%b want 00/00", fwd_a, fwd_b); end
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL rst_exv: got %b want 0", ex_valid); end
    reset = 1'b1;
    drain();
  endtask

  task automatic test_alu_chain();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 3'd1, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd1, 1'b0);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL alu_stall1: got %b want 0", stall); end
    tick();
    vectors++; if (fwd_a !== 2'b10) begin miscompares++; $display("FAIL alu_fwd_a_exmem: got %b want 10", fwd_a); end
    vectors++; if (ex_valid !== 1'b1) begin miscompares++; $display("FAIL alu_exv: got %b want 1", ex_valid); end
    drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 3'd1, 1'b0);
    tick();
    vectors++; if (fwd_b !== 2'b01 || fwd_a !== 2'b00) begin miscompares++; $display("FAIL alu_fwd_b_memwb: got %b/%b want a00 b01", fwd_a, fwd_b); end
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd1, 1'b0);
    tick();
    vectors++; if (fwd_a !== 2'b00) begin miscompares++; $display("FAIL alu_fwd_a_rf: got %b want 00", fwd_a); end
    vectors++; if (busy !== 32'h0) begin miscompares++; $display("FAIL alu_busy_clear: got %h want 0", busy); end
    drain();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 3'd4, 1'b0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd1, 1'b0);
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL ld_stall: got %b want 1", stall); end
    tick();
    vectors++; if (ex_valid !== 1'b0 || fwd_a !== 2'b00) begin miscompares++; $display("FAIL ld_bubble: got exv %b fwd_a %b want 0 00", ex_valid, fwd_a); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL ld_release: got %b want 0", stall); end
    tick();
    vectors++; if (fwd_a !== 2'b01 || ex_valid !== 1'b1) begin miscompares++; $display("FAIL ld_fwd_memwb: got fwd_a %b exv %b want 01 1", fwd_a, ex_valid); end
    tick();
    vectors++; if (fwd_a !== 2'b00) begin miscompares++; $display("FAIL ld_second_rf: got %b want 00", fwd_a); end
    drain();
  endtask

  task automatic test_multi_cycle();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 3'd3, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 3'd1, 1'b0);
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL mc_stall1: got %b want 1", stall); end
    tick();
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL mc_stall2: got %b want 1", stall); end
    tick();
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL mc_release: got %b want 0", stall); end
    tick();
    vectors++; if (fwd_b !== 2'b10 || ex_valid !== 1'b1) begin miscompares++; $display("FAIL mc_fwd_b: got fwd_b %b exv %b want 10 1", fwd_b, ex_valid); end
    drain();
  endtask

  task automatic test_waw();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 3'd4, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 3'd1, 1'b0);
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL waw_stall1: got %b want 1", stall); end
    tick();
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL waw_stall2: got %b want 1", stall); end
    tick();
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL waw_release: got %b want 0", stall); end
    tick();
    vectors++; if (busy !== 32'h8) begin miscompares++; $display("FAIL waw_busy: got %h want 00000008", busy); end
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd1, 1'b0);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL waw_consumer_stall: got %b want 0", stall); end
    tick();
    vectors++; if (fwd_a !== 2'b10) begin miscompares++; $display("FAIL waw_rem2_fwd: got %b want 10", fwd_a); end
    idle();
    tick();
    vectors++; if (busy !== 32'h0) begin miscompares++; $display("FAIL waw_drained: got %h want 0", busy); end
    drain();
  endtask

  task automatic test_r0_flush();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 3'd4, 1'b0);
    tick();
    vectors++; if (busy !== 32'h0 || ex_valid !== 1'b1) begin miscompares++; $display("FAIL r0_write: got busy %h exv %b want 0 1", busy, ex_valid); end
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 3'd2, 1'b0);
    tick();
    drive(1'b1, 5'd6, 1'b1, 5'd6, 1'b0, 5'd6, 1'b1, 1'b0, 3'd4, 1'b1);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall: got %b want 0", stall); end
    tick();
    vectors++; if (ex_valid !== 1'b0 || fwd_a !== 2'b00) begin miscompares++; $display("FAIL flush_exv: got exv %b fwd_a %b want 0 00", ex_valid, fwd_a); end
    vectors++; if (busy !== 32'h40) begin miscompares++; $display("FAIL flush_busy: got %h want 00000040", busy); end
    drive(1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0, 3'd1, 1'b0);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL disabled_src_stall: got %b want 0", stall); end
    drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd1, 1'b0);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL flush_table_stall: got %b want 0", stall); end
    tick();
    vectors++; if (fwd_a !== 2'b10) begin miscompares++; $display("FAIL flush_table_fwd: got %b want 10", fwd_a); end
    drain();
  endtask

  task automatic test_clamp_self();
    int n;
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 3'd7, 1'b0);
    tick();
    drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd1, 1'b0);
    n = 0;
    while (stall === 1'b1 && n < 10) begin n++; tick(); end
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL clamp_hi_stalls: got %0d want 3", n); end
    tick();
    vectors++; if (fwd_a !== 2'b10) begin miscompares++; $display("FAIL clamp_hi_fwd: got %b want 10", fwd_a); end
    drain();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 5'd0, 1'b0, 1'b0, 3'd1, 1'b0);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL clamp_lo_stall: got %b want 0", stall); end
    tick();
    vectors++; if (fwd_b !== 2'b10) begin miscompares++; $display("FAIL clamp_lo_fwd: got %b want 10", fwd_b); end
    drain();
    drive(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 3'd1, 1'b0);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL self_stall: got %b want 0", stall); end
    tick();
    vectors++; if (fwd_a !== 2'b00 || busy !== 32'h1000) begin miscompares++; $display("FAIL self_fwd: got fwd_a %b busy %h want 00 00001000", fwd_a, busy); end
    drive(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd1, 1'b0);
    tick();
    vectors++; if (fwd_a !== 2'b10) begin miscompares++; $display("FAIL self_next_fwd: got %b want 10", fwd_a); end
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    idle();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    test_reset();
    test_alu_chain();
    test_load_use();
    test_multi_cycle();
    test_waw();
    test_r0_flush();
    test_clamp_self();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
